// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: handshake bundle between the main control unit, the
// ALU control sequencer and the ALU/MDU.
//   Front end : in_valid, in_ready, instruction_code, ALUOp
//   Back end  : out_valid, out_ready, ALUControl, illegal
//   MDU       : mdu_start, mdu_busy
// Modports: master = producer/consumer side, slave = the sequencer.
interface alu_ctrl_seq_if #(
   parameter int CTRL_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instruction_code;
   logic [2:0]        ALUOp;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] ALUControl;
   logic              illegal;
   logic              mdu_start;
   logic              mdu_busy;

   modport slave (
      input  in_valid, instruction_code, ALUOp, out_ready,
      output in_ready, out_valid, ALUControl, illegal, mdu_start, mdu_busy
   );

   modport master (
      output in_valid, instruction_code, ALUOp, out_ready,
      input  in_ready, out_valid, ALUControl, illegal, mdu_start, mdu_busy
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with a one-entry registered output stage
// (valid/ready) and RV32M latency sequencing.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : alu_ctrl_seq_if.slave (front-end request, registered ALUControl /
//           illegal response, mdu_start pulse and mdu_busy)
// Optional feature: define ALU_CTRL_M_EXT_EN to enable RV32M decode and the
// MWAIT latency state. Without it M-ops decode as illegal ADD and the MDU
// outputs are tied low.
module alu_ctrl_seq #(
   parameter int CTRL_W  = 5,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 32
) (
   input  logic         clk,
   input  logic         reset,
   alu_ctrl_seq_if.slave bus
);
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

   localparam logic [4:0] C_AND  = 5'h00, C_OR   = 5'h01, C_ADD  = 5'h02,
                          C_SLL  = 5'h03, C_SRL  = 5'h04, C_SRA  = 5'h05,
                          C_SUB  = 5'h06, C_XOR  = 5'h07, C_SLT  = 5'h08,
                          C_SLTU = 5'h09, C_ADDI = 5'h0A;

   typedef enum logic [1:0] {IDLE, VALID, MWAIT} state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              ill_q, ill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              first_q, first_d;

   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] dec_code;
   logic       dec_ill;
   int         dec_lat;
   logic       load;
   logic       in_ready_c, out_valid_c, busy_c, start_c;

   assign f3 = bus.instruction_code[14:12];
   assign f7 = bus.instruction_code[31:25];

   // Only funct3/funct7 matter to this block.
   logic unused_instr;
   assign unused_instr = ^{bus.instruction_code[24:15], bus.instruction_code[11:0]};

   // Decode: every path lands on a defined code, illegal falls back to ADD.
   always_comb begin
      dec_code = C_AND;
      dec_ill  = 1'b0;
      dec_lat  = 0;
      case (bus.ALUOp)
         3'b000: dec_code = C_ADD;
         3'b001: begin
            case (f3)
               3'b000, 3'b001: dec_code = C_SUB;
               3'b100, 3'b101: dec_code = C_SLT;
               3'b110, 3'b111: dec_code = C_SLTU;
               default: begin dec_code = C_ADD; dec_ill = 1'b1; end
            endcase
         end
         3'b010: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  dec_code = C_ADD;
                  3'b001:  dec_code = C_SLL;
                  3'b010:  dec_code = C_SLT;
                  3'b011:  dec_code = C_SLTU;
                  3'b100:  dec_code = C_XOR;
                  3'b101:  dec_code = C_SRL;
                  3'b110:  dec_code = C_OR;
                  default: dec_code = C_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               if (f3 == 3'b000)      dec_code = C_SUB;
               else if (f3 == 3'b101) dec_code = C_SRA;
               else begin dec_code = C_ADD; dec_ill = 1'b1; end
            end else if (f7 == 7'b0000001) begin
`ifdef ALU_CTRL_M_EXT_EN
               // M codes are 0x10 + funct3; funct3[2] separates DIV/REM from MUL.
               dec_code = {2'b10, f3};
               dec_lat  = f3[2] ? DIV_LAT : MUL_LAT;
`else
               dec_code = C_ADD;
               dec_ill  = 1'b1;
`endif
            end else begin
               dec_code = C_ADD;
               dec_ill  = 1'b1;
            end
         end
         3'b100: begin
            case (f3)
               3'b000: dec_code = C_ADDI;
               3'b001: begin
                  if (f7 == 7'b0000000) dec_code = C_SLL;
                  else begin dec_code = C_ADD; dec_ill = 1'b1; end
               end
               3'b010: dec_code = C_SLT;
               3'b011: dec_code = C_SLTU;
               3'b100: dec_code = C_XOR;
               3'b101: begin
                  if (f7 == 7'b0000000)      dec_code = C_SRL;
                  else if (f7 == 7'b0100000) dec_code = C_SRA;
                  else begin dec_code = C_ADD; dec_ill = 1'b1; end
               end
               3'b110:  dec_code = C_OR;
               default: dec_code = C_AND;
            endcase
         end
         default: dec_code = C_AND;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      ill_d       = ill_q;
      cnt_d       = cnt_q;
      first_d     = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      start_c     = 1'b0;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            load       = bus.in_valid;
         end
         VALID: begin
            out_valid_c = 1'b1;
            in_ready_c  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) load = 1'b1;
               else              state_d = IDLE;
            end
         end
         MWAIT: begin
            busy_c  = 1'b1;
            start_c = first_q;
            if (cnt_q == '0) state_d = VALID;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Counter is preloaded with L-1 so MWAIT lasts exactly L cycles.
      if (load) begin
         ctrl_d = CTRL_W'(dec_code);
         ill_d  = dec_ill;
         if (dec_lat > 0) begin
            state_d = MWAIT;
            cnt_d   = CNT_W'(dec_lat - 1);
            first_d = 1'b1;
         end else begin
            state_d = VALID;
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.ALUControl = ctrl_q;
   assign bus.illegal    = ill_q;
`ifdef ALU_CTRL_M_EXT_EN
   assign bus.mdu_start  = start_c;
   assign bus.mdu_busy   = busy_c;
`else
   // MWAIT is unreachable here; outputs are held low explicitly.
   logic unused_mdu;
   assign unused_mdu     = start_c | busy_c;
   assign bus.mdu_start  = 1'b0;
   assign bus.mdu_busy   = 1'b0;
`endif
endmodule
